// File: rtl/otter_mc_ctrl_fsm.sv
// Multicycle OTTER sequencer: INIT -> FETCH -> EXEC [-> WB] with mem_rdy handshake and retired-instruction counter.
// Optional trap state enabled by defining OTTER_FSM_INTR_EN (adds intr / intr_taken ports).
module otter_mc_ctrl_fsm #(
    parameter int INIT_CYCLES = 2,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 mem_rdy,
`ifdef OTTER_FSM_INTR_EN
    input  logic                 intr,
    output logic                 intr_taken,
`endif
    output logic                 reset,
    output logic                 pc_we,
    output logic                 rf_we,
    output logic                 mem_we,
    output logic                 mem_re1,
    output logic                 mem_re2,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret,
    output logic [2:0]           state_o
);

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WB    = 3'd3;
`ifdef OTTER_FSM_INTR_EN
    localparam logic [2:0] ST_INTR  = 3'd4;
`endif

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    localparam logic [3:0]           CNT_INIT = 4'(INIT_CYCLES - 1);
    localparam logic [INSTRET_W-1:0] RET_ONE  = {{(INSTRET_W-1){1'b0}}, 1'b1};

    logic [2:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 retire;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        instret_d = instret_q;
        retire    = 1'b0;
        reset     = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        mem_we    = 1'b0;
        mem_re1   = 1'b0;
        mem_re2   = 1'b0;
        illegal   = 1'b0;
`ifdef OTTER_FSM_INTR_EN
        intr_taken = 1'b0;
`endif
        case (state_q)
            ST_INIT: begin
                reset = 1'b1;
                if (cnt_q == 4'd0) state_d = ST_FETCH;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_FETCH: begin
                mem_re1 = 1'b1;
                if (mem_rdy) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG: begin
                        rf_we  = 1'b1;
                        retire = 1'b1;
                    end
                    OP_BRANCH: retire = 1'b1;
                    OP_STORE: begin
                        mem_we = 1'b1;
                        retire = 1'b1;
                    end
                    OP_LOAD: begin
                        mem_re2 = 1'b1;
                        state_d = ST_WB;
                    end
                    default: begin
                        illegal = 1'b1;
                        retire  = 1'b1;
                    end
                endcase
            end
            ST_WB: begin
                mem_re2 = 1'b1;
                if (mem_rdy) begin
                    rf_we  = 1'b1;
                    retire = 1'b1;
                end
            end
`ifdef OTTER_FSM_INTR_EN
            ST_INTR: begin
                // Trap redirect writes the PC but is not itself a retired instruction.
                intr_taken = 1'b1;
                pc_we      = 1'b1;
                state_d    = ST_FETCH;
            end
`endif
            default: begin
                reset   = 1'b1;
                state_d = ST_INIT;
                cnt_d   = CNT_INIT;
            end
        endcase

        if (retire) begin
            pc_we     = 1'b1;
            instret_d = instret_q + RET_ONE;
`ifdef OTTER_FSM_INTR_EN
            state_d   = intr ? ST_INTR : ST_FETCH;
`else
            state_d   = ST_FETCH;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            cnt_q     <= CNT_INIT;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
    assign state_o = state_q;

endmodule
